// File: rtl/udp_frame_reader.sv
// Purpose: walks the just-completed ping-pong bank after each msync falling edge and streams it as one
//          packet (header {HDR_TAG, frame_cnt} with sop, then WORD_CNT payload words, eop on the last).
// Latency: header valid the cycle after msync is seen; payload word 0 by msync+2+RD_LAT; then 1 word/cycle.
// Backpressure: valid/ready; words held stable while stalled; read issue throttled by 4 prefetch credits.
// Ports: clk/rst_n (async active-low); i_msync_n main sync; o_rd_addr/i_rd_data buffer read port;
//        o_data/o_vld/i_rdy/o_sop/o_eop output stream; o_busy packet in progress; o_overrun dropped msync.
module udp_frame_reader #(
    parameter int          WORD_CNT = 512,
    parameter int          RD_LAT   = 2,
    parameter logic [15:0] HDR_TAG  = 16'hA55A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_msync_n,
    output logic [9:0]  o_rd_addr,
    input  logic [31:0] i_rd_data,
    output logic [31:0] o_data,
    output logic        o_vld,
    input  logic        i_rdy,
    output logic        o_sop,
    output logic        o_eop,
    output logic        o_busy,
    output logic        o_overrun
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    state_t      state_q, state_d;
    logic        msync_prev_q;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [10:0] iss_addr_q, iss_addr_d;   // next address the issuer will send
    logic        iss_act_q, iss_act_d;
    logic [9:0]  rd_addr_q, rd_addr_d;
    logic [RD_LAT:0] pipe_q, pipe_d;       // bit k set => read issued k cycles ago
    logic [2:0]  credit_q, credit_d;       // FIFO entries plus reads in flight
    logic [10:0] pop_cnt_q, pop_cnt_d;     // payload words already accepted this packet
    logic        overrun_q, overrun_d;
    logic [31:0] fifo_mem_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  fcnt_q;

    logic        msync, start, hdr_acc, pop, push, issue, eop_acc;
    logic [10:0] next_addr;

    // Same edge detect as the writer, so both sides flip on the same cycle.
    assign msync   = msync_prev_q & ~i_msync_n;
    assign start   = msync & (state_q == S_IDLE);
    assign hdr_acc = (state_q == S_HDR) & i_rdy;
    assign pop     = (state_q == S_DATA) & (fcnt_q != 3'd0) & i_rdy;
    assign eop_acc = pop & o_eop;
    // The returning word lands exactly RD_LAT cycles after its address was driven.
    assign push    = pipe_q[RD_LAT];

    // A credit freed by this cycle's pop can be reused at once; this keeps a
    // ready sink bubble-free with only four credits.
    assign next_addr = start ? 11'd0 : iss_addr_q;
    assign issue     = (start | iss_act_q) & ((credit_q < 3'd4) | pop);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (msync)   state_d = S_HDR;
            S_HDR:  if (i_rdy)   state_d = S_DATA;
            S_DATA: if (eop_acc) state_d = S_IDLE;
            default:             state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (from registers only) ----------------
    always_comb begin
        o_vld  = 1'b0;
        o_sop  = 1'b0;
        o_eop  = 1'b0;
        o_data = '0;
        unique case (state_q)
            S_HDR: begin
                o_vld  = 1'b1;
                o_sop  = 1'b1;
                o_data = {HDR_TAG, frame_cnt_q};
            end
            S_DATA: begin
                o_vld  = (fcnt_q != 3'd0);
                o_data = fifo_mem_q[rd_ptr_q];
                o_eop  = (fcnt_q != 3'd0) && (pop_cnt_q == 11'(WORD_CNT - 1));
            end
            default: ;
        endcase
    end

    assign o_busy    = (state_q != S_IDLE);
    assign o_overrun = overrun_q;
    assign o_rd_addr = rd_addr_q;

    // ---------------- read issuer and counters ----------------
    always_comb begin
        iss_act_d = iss_act_q | start;
        if (issue && (next_addr == 11'(WORD_CNT - 1))) iss_act_d = 1'b0;
        iss_addr_d  = issue ? next_addr + 11'd1 : iss_addr_q;
        rd_addr_d   = issue ? next_addr[9:0] : rd_addr_q;
        pipe_d      = {pipe_q[RD_LAT-1:0], issue};
        credit_d    = credit_q + {2'b0, issue} - {2'b0, pop};
        pop_cnt_d   = start ? 11'd0 : (pop ? pop_cnt_q + 11'd1 : pop_cnt_q);
        frame_cnt_d = frame_cnt_q + {15'd0, hdr_acc};
        // A msync while busy is reported and otherwise ignored.
        overrun_d   = msync & (state_q != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msync_prev_q <= 1'b1;
            frame_cnt_q  <= '0;
            iss_addr_q   <= '0;
            iss_act_q    <= 1'b0;
            rd_addr_q    <= '0;
            pipe_q       <= '0;
            credit_q     <= '0;
            pop_cnt_q    <= '0;
            overrun_q    <= 1'b0;
        end else begin
            msync_prev_q <= i_msync_n;
            frame_cnt_q  <= frame_cnt_d;
            iss_addr_q   <= iss_addr_d;
            iss_act_q    <= iss_act_d;
            rd_addr_q    <= rd_addr_d;
            pipe_q       <= pipe_d;
            credit_q     <= credit_d;
            pop_cnt_q    <= pop_cnt_d;
            overrun_q    <= overrun_d;
        end
    end

    // ---------------- 4-deep prefetch FIFO (credits make overflow impossible) ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) fifo_mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= i_rd_data;
                wr_ptr_q             <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            fcnt_q <= fcnt_q + {2'b0, push} - {2'b0, pop};
        end
    end

endmodule

// File: tb/tb_udp_frame_reader.sv
module tb_udp_frame_reader;
    localparam int WC  = 512;
    localparam int WC1 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, msync_n, rdy, rdy1;
    logic [9:0]  addr2, addr1;
    logic [31:0] rdd2, rdd1, dat2, dat1;
    logic        vld2, sop2, eop2, busy2, ovr2;
    logic        vld1, sop1, eop1, busy1, ovr1;

    udp_frame_reader #(.WORD_CNT(WC), .RD_LAT(2), .HDR_TAG(16'hA55A)) u2 (
        .clk(clk), .rst_n(rst_n), .i_msync_n(msync_n), .o_rd_addr(addr2), .i_rd_data(rdd2),
        .o_data(dat2), .o_vld(vld2), .i_rdy(rdy), .o_sop(sop2), .o_eop(eop2),
        .o_busy(busy2), .o_overrun(ovr2));

    udp_frame_reader #(.WORD_CNT(WC1), .RD_LAT(1), .HDR_TAG(16'hA55A)) u1 (
        .clk(clk), .rst_n(rst_n), .i_msync_n(msync_n), .o_rd_addr(addr1), .i_rd_data(rdd1),
        .o_data(dat1), .o_vld(vld1), .i_rdy(rdy1), .o_sop(sop1), .o_eop(eop1),
        .o_busy(busy1), .o_overrun(ovr1));

    // RAM models: data = addr * 3, with 2-cycle and 1-cycle read latency.
    logic [31:0] r2a, r2b, r1a;
    always @(posedge clk) begin
        r2a <= 32'(addr2) * 32'd3;
        r2b <= r2a;
        r1a <= 32'(addr1) * 32'd3;
    end
    assign rdd2 = r2b;
    assign rdd1 = r1a;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {logic [31:0] dat; logic sop; logic eop;} word_t;
    word_t exp_q[$];

    typedef struct {int mode; logic [31:0] hdr; int ovr_off; int exp_ovr;} vec_t;

    int n_chk = 0, n_err = 0;
    int ovr_cnt = 0, pay_cnt = 0, eop_cnt = 0, gap_cnt = 0, first_cyc = 0, eop_cyc = 0;
    int rdy_mode = 0, msync_cnt = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    // Monitor / scoreboard consumer for the RD_LAT=2 instance; also drives its ready.
    initial begin
        word_t e;
        bit stall_q, in_pay;
        logic [31:0] pd;
        logic ps, pe;
        stall_q = 0; in_pay = 0; pd = '0; ps = 0; pe = 0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = 1'b0;
            endcase
            if (!mon_en) begin
                exp_q.delete();
                stall_q = 0;
                in_pay  = 0;
            end else begin
                if (stall_q) begin
                    chk("hold_vld", 32'(vld2), 32'd1);
                    chk("hold_dat", dat2, pd);
                    chk("hold_flags", 32'({sop2, eop2}), 32'({ps, pe}));
                end
                if (ovr2) ovr_cnt++;
                if (in_pay && !vld2 && rdy_mode == 0) gap_cnt++;
                if (vld2 && rdy) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_word", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_dat", dat2, e.dat);
                        chk("word_flags", 32'({sop2, eop2}), 32'({e.sop, e.eop}));
                    end
                    if (!sop2) begin
                        if (!in_pay) first_cyc = cyc;
                        in_pay = 1;
                        pay_cnt++;
                    end
                    if (eop2) begin
                        in_pay  = 0;
                        eop_cyc = cyc;
                        eop_cnt++;
                    end
                end
                stall_q = vld2 && !rdy;
                pd = dat2; ps = sop2; pe = eop2;
            end
        end
    end

    task automatic push_frame(input logic [31:0] hdr);
        exp_q.push_back('{dat: hdr, sop: 1'b1, eop: 1'b0});
        for (int i = 0; i < WC; i++)
            exp_q.push_back('{dat: 32'(i * 3), sop: 1'b0, eop: (i == WC - 1)});
    endtask

    task automatic finish_checks(input int e0, input int p0);
        for (int c = 0; c < 6000 && eop_cnt == e0; c++) @(negedge clk);
        chk("frame_done", 32'(eop_cnt - e0), 32'd1);
        chk("payload_count", 32'(pay_cnt - p0), 32'(WC));
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_frame(input int mode, input logic [31:0] hdr, input int ovr_off, input int exp_ovr);
        int p0, o0, g0, e0, m;
        rdy_mode = mode;
        p0 = pay_cnt; o0 = ovr_cnt; g0 = gap_cnt; e0 = eop_cnt;
        push_frame(hdr);
        msync_n = 1'b0; msync_cnt++; m = cyc;
        for (int c = 0; c < 6000 && eop_cnt == e0; c++) begin
            @(negedge clk);
            if (c == 3) msync_n = 1'b1;
            if (ovr_off >= 0) begin
                if (c == ovr_off) begin msync_n = 1'b0; msync_cnt++; end
                if (c == ovr_off + 1) chk("overrun_pulse", 32'(ovr2), 32'd1);
                if (c == ovr_off + 2) chk("overrun_single", 32'(ovr2), 32'd0);
                if (c == ovr_off + 4) msync_n = 1'b1;
            end
        end
        msync_n = 1'b1;
        finish_checks(e0, p0);
        chk("overruns", 32'(ovr_cnt - o0), 32'(exp_ovr));
        if (mode == 0) begin
            chk("gaps", 32'(gap_cnt - g0), 32'd0);
            chk("first_word_lat_ok", 32'(first_cyc - m <= 4), 32'd1);
            chk("eop_lat_ok", 32'(eop_cyc - m <= 3 + WC), 32'd1);
        end
        repeat (20) @(negedge clk);
        chk("idle_after", 32'({busy2, vld2}), 32'd0);
    endtask

    initial begin
        vec_t tbl[5];
        int idx, fc1, e0, p0;
        logic [31:0] ed;
        logic es, ee;

        tbl[0] = '{0, 32'hA55A0000, -1, 0};
        tbl[1] = '{1, 32'hA55A0001, -1, 0};
        tbl[2] = '{1, 32'hA55A0002, -1, 0};
        tbl[3] = '{0, 32'hA55A0003, 100, 1};
        tbl[4] = '{1, 32'hA55A0004, 600, 1};

        rst_n = 1'b0; msync_n = 1'b1; rdy1 = 1'b1; rdy_mode = 0;
        repeat (3) @(negedge clk);
        chk("rst_vld", 32'(vld2), 32'd0);
        chk("rst_sop_eop", 32'({sop2, eop2}), 32'd0);
        chk("rst_busy_ovr", 32'({busy2, ovr2}), 32'd0);
        chk("rst_addr", 32'(addr2), 32'd0);
        chk("rst_data", dat2, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 5; i++) run_frame(tbl[i].mode, tbl[i].hdr, tbl[i].ovr_off, tbl[i].exp_ovr);

        // Stall both instances for 20 cycles right after msync: issue must stop at 4 outstanding.
        rdy_mode = 2; rdy1 = 1'b0;
        fc1 = msync_cnt;
        e0 = eop_cnt; p0 = pay_cnt;
        push_frame(32'hA55A0005);
        msync_n = 1'b0; msync_cnt++;
        repeat (3) @(negedge clk);
        msync_n = 1'b1;
        repeat (17) @(negedge clk);
        chk("stall_addr_lat2", 32'(addr2), 32'd3);
        chk("stall_addr_lat1", 32'(addr1), 32'd3);
        chk("stall_hdr_held", 32'({vld2, sop2}), 32'd3);
        rdy_mode = 0; rdy1 = 1'b1;
        idx = 0;
        for (int c = 0; c < 100 && idx <= WC1; c++) begin
            if (vld1) begin
                if (idx == 0) begin ed = {16'hA55A, 16'(fc1)}; es = 1'b1; ee = 1'b0; end
                else begin ed = 32'((idx - 1) * 3); es = 1'b0; ee = (idx == WC1); end
                chk("lat1_dat", dat1, ed);
                chk("lat1_flags", 32'({sop1, eop1}), 32'({es, ee}));
                idx++;
            end
            @(negedge clk);
        end
        chk("lat1_words", 32'(idx), 32'(WC1 + 1));
        finish_checks(e0, p0);
        repeat (20) @(negedge clk);

        // Reset in the middle of a packet, then a clean packet from address 0.
        push_frame(32'hA55A0006);
        msync_n = 1'b0; msync_cnt++;
        repeat (3) @(negedge clk);
        msync_n = 1'b1;
        repeat (97) @(negedge clk);
        mon_en = 1'b0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_vld_busy", 32'({vld2, busy2}), 32'd0);
        chk("midrst_addr", 32'(addr2), 32'd0);
        chk("midrst_eop", 32'(eop2), 32'd0);
        rst_n = 1'b1; msync_cnt = 0;
        @(negedge clk);
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        e0 = eop_cnt; p0 = pay_cnt;
        push_frame(32'hA55A0000);
        msync_n = 1'b0; msync_cnt++;
        @(negedge clk);
        chk("post_rst_hdr", dat2, 32'hA55A0000);
        chk("post_rst_addr0", 32'(addr2), 32'd0);
        @(negedge clk);
        chk("post_rst_addr1", 32'(addr2), 32'd1);
        msync_n = 1'b1;
        finish_checks(e0, p0);
        repeat (20) @(negedge clk);

        // Frame counter wrap.
        force u2.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release u2.frame_cnt_q;
        @(negedge clk);
        run_frame(0, 32'hA55AFFFF, -1, 0);
        run_frame(1, 32'hA55A0000, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
